lamp_conflict_monitor: RTL and testbench



---
 rtl/traffic_pkg.sv | 39 +++
 rtl/approach_dark_timer.sv | 47 ++++
 rtl/lamp_conflict_monitor.sv | 187 ++++++++++++++++++
 tb/tb_lamp_conflict_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic-light slice: sequencer state encodings,
// conflict-monitor state encodings, fault-code constants, default counter
// width and a small lamp-combination helper.
// No ports (package).
// -----------------------------------------------------------------------------
package traffic_pkg;

   localparam int unsigned DEFAULT_CNT_W = 13;

   typedef enum logic [2:0] {
      SEQ_MAIN_GREEN  = 3'd0,
      SEQ_MAIN_YELLOW = 3'd1,
      SEQ_ALL_RED_A   = 3'd2,
      SEQ_SIDE_GREEN  = 3'd3,
      SEQ_SIDE_YELLOW = 3'd4,
      SEQ_ALL_RED_B   = 3'd5,
      SEQ_BLINK_ON    = 3'd6,
      SEQ_BLINK_OFF   = 3'd7
   } seq_state_e;

   typedef enum logic [1:0] {
      MONITOR     = 2'd0,
      FAULT_FLASH = 2'd1,
      CLEAR_HOLD  = 2'd2
   } mon_state_e;

   localparam logic [2:0] FC_NONE     = 3'b000;
   localparam logic [2:0] FC_CONFLICT = 3'b001;
   localparam logic [2:0] FC_MULTI    = 3'b010;
   localparam logic [2:0] FC_DARK     = 3'b011;

   // True when two or more of an approach's {R,Y,G} requests are set.
   function automatic logic two_or_more(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/approach_dark_timer.sv
// -----------------------------------------------------------------------------
// approach_dark_timer
// Saturating count of consecutive cycles in which an approach requests no lamp.
// Ports:
//   clk_50  - system clock
//   reset   - asynchronous, active-high reset
//   lamps_i - {R,Y,G} requests of one approach
//   clear_i - synchronous clear (fault acknowledge)
//   dark_o  - counter has reached DARK_CYCLES
// -----------------------------------------------------------------------------
module approach_dark_timer
   import traffic_pkg::*;
#(
   parameter int unsigned DARK_CYCLES = 3000,
   parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
   input  logic       clk_50,
   input  logic       reset,
   input  logic [2:0] lamps_i,
   input  logic       clear_i,
   output logic       dark_o
);

   localparam logic [CNT_W-1:0] DARK_MAX = CNT_W'(DARK_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || (|lamps_i)) begin
         cnt_d = '0;
      end else if (cnt_q != DARK_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign dark_o = (cnt_q == DARK_MAX);

endmodule

// File: rtl/lamp_conflict_monitor.sv
// -----------------------------------------------------------------------------
// lamp_conflict_monitor
// Registers the sequencer's lamp requests onto the lamp drives and watches for
// unsafe combinations (conflicting greens, several lamps on one approach, an
// approach dark for too long). A violation persisting FILTER_CYCLES cycles
// latches a fault code and forces flashing all-red until fault_clear, followed
// by a FLASH_HALF-cycle steady all-red hold.
// Optional: define FAULT_COUNT_EN to add the saturating fault_count output.
// Ports:
//   clk_50, reset             - clock, asynchronous active-high reset
//   main_{R,Y,G}_i            - main-approach lamp requests
//   side_{R,Y,G}_i            - side-approach lamp requests
//   fault_clear               - single-cycle fault exit request
//   main_{R,Y,G}, side_{R,Y,G}- registered lamp drives
//   fault                     - high in FAULT_FLASH or CLEAR_HOLD
//   fault_code                - latched cause (none/conflict/multi/dark)
//   fault_count               - fault entries, saturating (FAULT_COUNT_EN only)
// -----------------------------------------------------------------------------
module lamp_conflict_monitor
   import traffic_pkg::*;
#(
   parameter int unsigned FILTER_CYCLES = 4,
   parameter int unsigned DARK_CYCLES   = 3000,
   parameter int unsigned FLASH_HALF    = 250,
   parameter int unsigned CNT_W         = DEFAULT_CNT_W
) (
   input  logic       clk_50,
   input  logic       reset,
   input  logic       main_R_i,
   input  logic       main_Y_i,
   input  logic       main_G_i,
   input  logic       side_R_i,
   input  logic       side_Y_i,
   input  logic       side_G_i,
   input  logic       fault_clear,
   output logic       main_R,
   output logic       main_Y,
   output logic       main_G,
   output logic       side_R,
   output logic       side_Y,
   output logic       side_G,
   output logic       fault,
   output logic [2:0] fault_code
`ifdef FAULT_COUNT_EN
   ,
   output logic [7:0] fault_count
`endif
);

   localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(FILTER_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);
   localparam logic [5:0]       ALL_RED    = 6'b100_100;

   mon_state_e       state_q, state_d;
   logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic             phase_q, phase_d;
   logic [5:0]       lamps_q, lamps_d;   // {mR,mY,mG,sR,sY,sG}
   logic             fault_q, fault_d;
   logic [2:0]       code_q, code_d;

   logic conflict, multi, dark_main, dark_side, viol, confirm, clear_acc;
   logic enter_flash;
   logic [2:0] code_now;

   approach_dark_timer #(.DARK_CYCLES(DARK_CYCLES), .CNT_W(CNT_W)) u_dark_main (
      .clk_50 (clk_50),
      .reset  (reset),
      .lamps_i({main_R_i, main_Y_i, main_G_i}),
      .clear_i(clear_acc),
      .dark_o (dark_main)
   );

   approach_dark_timer #(.DARK_CYCLES(DARK_CYCLES), .CNT_W(CNT_W)) u_dark_side (
      .clk_50 (clk_50),
      .reset  (reset),
      .lamps_i({side_R_i, side_Y_i, side_G_i}),
      .clear_i(clear_acc),
      .dark_o (dark_side)
   );

   assign conflict  = (main_G_i & ~side_R_i) | (side_G_i & ~main_R_i);
   assign multi     = two_or_more({main_R_i, main_Y_i, main_G_i}) |
                      two_or_more({side_R_i, side_Y_i, side_G_i});
   assign viol      = conflict | multi | dark_main | dark_side;
   // Confirmation only matters outside FAULT_FLASH; in the flash the fault is
   // already latched and only fault_clear can move the state.
   assign confirm   = viol && (viol_cnt_q == FILT_LAST) && (state_q != FAULT_FLASH);
   assign clear_acc = (state_q == FAULT_FLASH) && fault_clear && !conflict && !multi;
   assign code_now  = conflict ? FC_CONFLICT : (multi ? FC_MULTI : FC_DARK);

   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      phase_d     = phase_q;
      code_d      = code_q;
      enter_flash = 1'b0;

      if (clear_acc || !viol) begin
         viol_cnt_d = '0;
      end else if (viol_cnt_q != FILT_LAST) begin
         viol_cnt_d = viol_cnt_q + CNT_W'(1);
      end else begin
         viol_cnt_d = viol_cnt_q;
      end

      unique case (state_q)
         MONITOR, CLEAR_HOLD: begin
            if (confirm) begin
               enter_flash = 1'b1;
               state_d     = FAULT_FLASH;
               code_d      = code_now;
               phase_d     = 1'b1;
               tmr_d       = '0;
            end else if (state_q == CLEAR_HOLD) begin
               if (tmr_q == FLASH_LAST) begin
                  state_d = MONITOR;
                  code_d  = FC_NONE;
                  tmr_d   = '0;
               end else begin
                  tmr_d = tmr_q + CNT_W'(1);
               end
            end
         end
         FAULT_FLASH: begin
            if (clear_acc) begin
               state_d = CLEAR_HOLD;
               tmr_d   = '0;
            end else if (tmr_q == FLASH_LAST) begin
               tmr_d   = '0;
               phase_d = ~phase_q;
            end else begin
               tmr_d = tmr_q + CNT_W'(1);
            end
         end
         default: state_d = MONITOR;
      endcase

      // Outputs follow the next state so they change on the same edge.
      unique case (state_d)
         FAULT_FLASH: lamps_d = {phase_d, 2'b00, phase_d, 2'b00};
         CLEAR_HOLD:  lamps_d = ALL_RED;
         default:     lamps_d = {main_R_i, main_Y_i, main_G_i,
                                 side_R_i, side_Y_i, side_G_i};
      endcase
      fault_d = (state_d != MONITOR);
   end

   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         state_q    <= MONITOR;
         viol_cnt_q <= '0;
         tmr_q      <= '0;
         phase_q    <= 1'b0;
         lamps_q    <= ALL_RED;
         fault_q    <= 1'b0;
         code_q     <= FC_NONE;
      end else begin
         state_q    <= state_d;
         viol_cnt_q <= viol_cnt_d;
         tmr_q      <= tmr_d;
         phase_q    <= phase_d;
         lamps_q    <= lamps_d;
         fault_q    <= fault_d;
         code_q     <= code_d;
      end
   end

   assign {main_R, main_Y, main_G, side_R, side_Y, side_G} = lamps_q;
   assign fault      = fault_q;
   assign fault_code = code_q;

`ifdef FAULT_COUNT_EN
   logic [7:0] fcnt_q;

   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         fcnt_q <= '0;
      end else if (enter_flash && (fcnt_q != 8'hFF)) begin
         fcnt_q <= fcnt_q + 8'd1;
      end
   end

   assign fault_count = fcnt_q;
`endif

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// -----------------------------------------------------------------------------
// tb_lamp_conflict_monitor
// Self-checking bench: a cycle-level reference model of the lamp monitor
// (run lengths, time-since-entry arithmetic) compared against the DUT after
// every clock edge, plus directed scenarios with hand-computed expectations.
// Optional: compile with FAULT_COUNT_EN to also check fault_count.
// -----------------------------------------------------------------------------
module tb_lamp_conflict_monitor;

   localparam int FILTER = 4;
   localparam int DARKN  = 3000;
   localparam int FH     = 250;

   // {mR,mY,mG,sR,sY,sG}
   localparam logic [5:0] P_MG    = 6'b001_100;
   localparam logic [5:0] P_MY    = 6'b010_100;
   localparam logic [5:0] P_ALLR  = 6'b100_100;
   localparam logic [5:0] P_SG    = 6'b100_001;
   localparam logic [5:0] P_SY    = 6'b100_010;
   localparam logic [5:0] P_YY    = 6'b010_010;
   localparam logic [5:0] P_DARK  = 6'b000_000;
   localparam logic [5:0] P_CONF  = 6'b001_001;
   localparam logic [5:0] P_MULTI = 6'b101_100;
   localparam logic [5:0] P_SDARK = 6'b100_000;

   logic clk_50 = 1'b0;
   logic reset  = 1'b1;
   logic main_R_i = 1'b1, main_Y_i = 1'b0, main_G_i = 1'b0;
   logic side_R_i = 1'b1, side_Y_i = 1'b0, side_G_i = 1'b0;
   logic fault_clear = 1'b0;
   logic main_R, main_Y, main_G, side_R, side_Y, side_G, fault;
   logic [2:0] fault_code;
`ifdef FAULT_COUNT_EN
   logic [7:0] fault_count;
`endif

   int tests = 0;
   int fails = 0;

   always #10 clk_50 = ~clk_50;

   lamp_conflict_monitor #(
      .FILTER_CYCLES(FILTER),
      .DARK_CYCLES  (DARKN),
      .FLASH_HALF   (FH),
      .CNT_W        (13)
   ) dut (
      .clk_50     (clk_50),
      .reset      (reset),
      .main_R_i   (main_R_i),
      .main_Y_i   (main_Y_i),
      .main_G_i   (main_G_i),
      .side_R_i   (side_R_i),
      .side_Y_i   (side_Y_i),
      .side_G_i   (side_G_i),
      .fault_clear(fault_clear),
      .main_R     (main_R),
      .main_Y     (main_Y),
      .main_G     (main_G),
      .side_R     (side_R),
      .side_Y     (side_Y),
      .side_G     (side_G),
      .fault      (fault),
      .fault_code (fault_code)
`ifdef FAULT_COUNT_EN
      ,
      .fault_count(fault_count)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int       m_mode = 0;          // 0 monitor, 1 flashing, 2 holding red
   int       m_entry = 0;         // index of first cycle spent in the current fault mode
   int       m_cyc = 0;
   int       m_dark_m = 0, m_dark_s = 0;  // consecutive dark cycles seen so far
   int       m_viol_run = 0;
   int       m_code = 0;
   int       m_count = 0;
   logic [5:0] m_lamps = P_ALLR;

   always @(posedge clk_50) begin
      int  nm, ns;
      bit  conflict, multi, dark, viol;
      logic [5:0] in;
      in = {main_R_i, main_Y_i, main_G_i, side_R_i, side_Y_i, side_G_i};
      if (reset) begin
         m_mode = 0; m_code = 0; m_count = 0;
         m_dark_m = 0; m_dark_s = 0; m_viol_run = 0;
      end else begin
         nm = int'(in[5]) + int'(in[4]) + int'(in[3]);
         ns = int'(in[2]) + int'(in[1]) + int'(in[0]);
         conflict = (in[3] && !in[2]) || (in[0] && !in[5]);
         multi    = (nm >= 2) || (ns >= 2);
         dark     = (m_dark_m >= DARKN) || (m_dark_s >= DARKN);
         viol     = conflict || multi || dark;
         m_dark_m = (nm == 0) ? m_dark_m + 1 : 0;
         m_dark_s = (ns == 0) ? m_dark_s + 1 : 0;
         m_viol_run = viol ? m_viol_run + 1 : 0;
         case (m_mode)
            1: if (fault_clear && !conflict && !multi) begin
                  m_mode = 2; m_entry = m_cyc + 1;
                  m_dark_m = 0; m_dark_s = 0; m_viol_run = 0;
               end
            default: begin
               if (m_viol_run >= FILTER) begin
                  m_mode  = 1; m_entry = m_cyc + 1;
                  m_code  = conflict ? 1 : (multi ? 2 : 3);
                  if (m_count < 255) m_count++;
               end else if (m_mode == 2 && m_cyc == m_entry + FH - 1) begin
                  m_mode = 0; m_code = 0;
               end
            end
         endcase
      end
      m_cyc++;
      if (reset || m_mode == 2) m_lamps = P_ALLR;
      else if (m_mode == 1)
         m_lamps = (((m_cyc - m_entry) / FH) % 2 == 0) ? P_ALLR : P_DARK;
      else m_lamps = in;

      #1;
      chk("lamps", int'({main_R, main_Y, main_G, side_R, side_Y, side_G}), int'(m_lamps));
      chk("fault", int'(fault), (m_mode != 0) ? 1 : 0);
      chk("code", int'(fault_code), m_code);
`ifdef FAULT_COUNT_EN
      chk("count", int'(fault_count), m_count);
`endif
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [5:0] v, input logic clr, input int n);
      {main_R_i, main_Y_i, main_G_i, side_R_i, side_Y_i, side_G_i} = v;
      fault_clear = clr;
      repeat (n) @(negedge clk_50);
      fault_clear = 1'b0;
   endtask

   logic [5:0] legal [7];

   initial begin
      legal[0] = P_MG; legal[1] = P_MY; legal[2] = P_ALLR; legal[3] = P_SG;
      legal[4] = P_SY; legal[5] = P_YY; legal[6] = P_DARK;

      repeat (3) @(negedge clk_50);
      chk("rst_lamps", int'({main_R, main_Y, main_G, side_R, side_Y, side_G}), 36);
      chk("rst_fault", int'(fault), 0);
      reset = 1'b0;

      // Normal operation mirrors the inputs
      drive(P_SG, 1'b0, 1500);
      chk("mirror_sg", int'({main_R, main_G, side_R, side_G}), 4'b1001);

      // Filter boundary: 3 conflicting cycles are tolerated, 4 are not
      drive(P_CONF, 1'b0, 3);
      drive(P_SG, 1'b0, 5);
      chk("filter3_nofault", int'(fault), 0);
      drive(P_CONF, 1'b0, 4);
      chk("conf_fault", int'(fault), 1);
      chk("conf_code", int'(fault_code), 1);
      chk("flash_lit", int'({main_R, side_R, main_G, side_G}), 4'b1100);
      drive(P_SG, 1'b0, FH - 1);
      chk("flash_lit_end", int'(main_R), 1);
      drive(P_SG, 1'b0, 1);
      chk("flash_dark", int'(main_R), 0);

      // Clear during a conflict is ignored; a clean clear starts the red hold
      drive(P_CONF, 1'b1, 1);
      drive(P_SG, 1'b0, FH + 10);
      chk("clr_ignored", int'(fault), 1);
      drive(P_SG, 1'b1, 1);
      drive(P_SG, 1'b0, 10);
      chk("hold_red", int'({main_R, side_R, side_G}), 3'b110);
      drive(P_CONF, 1'b0, 4);
      chk("hold_refault", int'(fault_code), 1);
      drive(P_SG, 1'b0, FH + 10);
      chk("hold_refault_stays", int'(fault), 1);
      drive(P_SG, 1'b1, 1);
      drive(P_SG, 1'b0, FH - 1);
      chk("hold_end_last", int'(fault), 1);
      drive(P_SG, 1'b0, 1);
      chk("hold_exit", int'(fault), 0);
      chk("hold_exit_code", int'(fault_code), 0);

      // Multi-lamp on one approach
      drive(P_MULTI, 1'b0, 4);
      chk("multi_code", int'(fault_code), 2);
      drive(P_SG, 1'b1, 1);
      drive(P_SG, 1'b0, FH + 5);

      // Side approach dark for too long
      drive(P_SDARK, 1'b0, DARKN + 3);
      chk("dark_pre", int'(fault), 0);
      drive(P_SDARK, 1'b0, 1);
      chk("dark_code", int'(fault_code), 3);
      drive(P_SG, 1'b1, 1);
      drive(P_SG, 1'b0, FH + 5);

      // Blink pattern with its 251-cycle dark phase is legal
      for (int i = 0; i < 4; i++) begin
         drive(P_YY, 1'b0, 250);
         drive(P_DARK, 1'b0, 251);
      end
      chk("blink_ok", int'(fault), 0);

      // Randomised traffic, mostly legal with occasional illegal bursts
      for (int i = 0; i < 1200; i++) begin
         logic [5:0] v;
         if ($urandom_range(0, 5) == 0) v = 6'($urandom);
         else v = legal[$urandom_range(0, 6)];
         drive(v, ($urandom_range(0, 9) == 0), $urandom_range(1, 8));
      end

      // Force a fault and reset in the middle of the flash
      drive(P_CONF, 1'b0, 4);
      chk("pre_reset_fault", int'(fault), 1);
      drive(P_SG, 1'b0, 20);
      reset = 1'b1;
      #1;
      chk("midrst_lamps", int'({main_R, main_Y, main_G, side_R, side_Y, side_G}), 36);
      chk("midrst_fault", int'(fault), 0);
      chk("midrst_code", int'(fault_code), 0);
`ifdef FAULT_COUNT_EN
      chk("midrst_count", int'(fault_count), 0);
`endif
      repeat (2) @(negedge clk_50);
      reset = 1'b0;
      drive(P_SG, 1'b0, 10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
